formula_arg_gen: RTL and testbench

- Synthesizable stimulus source sitting directly upstream of the formula pipelines (formula_1_pipe, formula_2_pipe, formula_2_pipe_using_fifos); drives their arg_vld/a/b/c inputs.
- Observes res_vld to track outstanding transactions.
- Replays the directed/random test sequence in hardware for FPGA-board self-test, with a credit limit and drain/timeout checks.

---
 rtl/formula_arg_gen.sv | 271 +++++++++++++++++++++++++++
 tb/tb_formula_arg_gen.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/formula_arg_gen.sv
// Hardware stimulus source for the formula pipelines: replays burst, delayed and
// LFSR-random argument phases with a credit limit, drain checks and sticky error flags.
module formula_arg_gen #(
    parameter int unsigned arg_width       = 32,
    parameter int unsigned n_random        = 10,
    parameter int unsigned max_outstanding = 16,
    parameter logic [31:0] lfsr_seed       = 32'h1,
    parameter int unsigned drain_timeout   = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 res_vld,
    output logic                 arg_vld,
    output logic [arg_width-1:0] a,
    output logic [arg_width-1:0] b,
    output logic [arg_width-1:0] c,
    output logic                 busy,
    output logic                 done,
    output logic                 err_underflow,
    output logic                 err_timeout,
    output logic [15:0]          arg_cnt,
    output logic [15:0]          res_cnt
);

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_BURST  = 4'd1;
    localparam logic [3:0] ST_DRAIN1 = 4'd2;
    localparam logic [3:0] ST_DELAY  = 4'd3;
    localparam logic [3:0] ST_GAP    = 4'd4;
    localparam logic [3:0] ST_DRAIN2 = 4'd5;
    localparam logic [3:0] ST_RANDOM = 4'd6;
    localparam logic [3:0] ST_RGAP   = 4'd7;
    localparam logic [3:0] ST_DRAIN3 = 4'd8;
    localparam logic [3:0] ST_DONE   = 4'd9;

    localparam logic [31:0]          SEED        = (lfsr_seed == 32'h0) ? 32'h1 : lfsr_seed;
    localparam logic [31:0]          LFSR_MASK   = 32'h8020_0003;
    localparam logic [15:0]          MAX_OUT     = 16'(max_outstanding);
    localparam logic [15:0]          N_RND       = 16'(n_random);
    localparam logic [31:0]          TMO_LAST    = 32'(drain_timeout - 1);
    localparam logic [arg_width-1:0] BURST_LIMIT = arg_width'(100);
    localparam logic [arg_width-1:0] DELAY_LIMIT = arg_width'(1000);
    localparam logic [arg_width-1:0] ONE         = arg_width'(1);

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? LFSR_MASK : 32'h0);
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    logic [3:0]           state_q, state_d, st_s;
    logic [arg_width-1:0] i_q, i_d, i_s, i_next_s, gap_q, gap_d;
    logic [arg_width-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [31:0]          lfsr_q, lfsr_d, lfsr_s, wait_q, wait_d;
    logic [15:0]          out_q, out_d, rnd_q, rnd_d, rnd_s, rnd_next_s;
    logic [15:0]          arg_cnt_q, arg_cnt_d, arg_base_s, res_cnt_q, res_cnt_d;
    logic                 arg_vld_q, arg_vld_d, busy_q, busy_d, done_q, done_d;
    logic                 err_u_q, err_u_d, err_t_q, err_t_d, can_issue_s;

    // Next-state: start folds into the same cycle so the first argument follows it directly.
    always_comb begin
        st_s       = state_q;
        i_s        = i_q;
        lfsr_s     = lfsr_q;
        rnd_s      = rnd_q;
        arg_base_s = arg_cnt_q;
        res_cnt_d  = res_cnt_q;
        err_u_d    = err_u_q;
        err_t_d    = err_t_q;
        out_d      = out_q;
        if (start && (state_q == ST_IDLE || state_q == ST_DONE)) begin
            st_s       = ST_BURST;
            i_s        = {arg_width{1'b0}};
            lfsr_s     = SEED;
            rnd_s      = 16'd0;
            arg_base_s = 16'd0;
            res_cnt_d  = 16'd0;
            err_u_d    = 1'b0;
            err_t_d    = 1'b0;
            out_d      = 16'd0;
        end else if (state_q != ST_IDLE) begin
            if (res_vld) begin
                res_cnt_d = sat_inc16(res_cnt_q);
            end else begin
                res_cnt_d = res_cnt_q;
            end
            if (arg_vld_q && !res_vld) begin
                out_d = out_q + 16'd1;
            end else if (res_vld && !arg_vld_q && out_q == 16'd0) begin
                err_u_d = 1'b1;
            end else if (res_vld && !arg_vld_q) begin
                out_d = out_q - 16'd1;
            end else begin
                out_d = out_q;
            end
        end else begin
            out_d = out_q;
        end

        can_issue_s = (out_d < MAX_OUT);
        i_next_s    = i_s * arg_width'(3) + ONE;
        rnd_next_s  = rnd_s + 16'd1;
        state_d     = st_s;
        i_d         = i_s;
        lfsr_d      = lfsr_s;
        rnd_d       = rnd_s;
        gap_d       = gap_q;
        wait_d      = 32'd0;
        arg_vld_d   = 1'b0;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;

        case (st_s)
            ST_BURST: begin
                if (can_issue_s) begin
                    arg_vld_d = 1'b1;
                    a_d       = i_s;
                    b_d       = i_s;
                    c_d       = i_s;
                    i_d       = i_next_s;
                    state_d   = (i_next_s >= BURST_LIMIT) ? ST_DRAIN1 : ST_BURST;
                end else begin
                    state_d = ST_BURST;
                end
            end
            ST_DRAIN1, ST_DRAIN2, ST_DRAIN3: begin
                if (out_d == 16'd0) begin
                    if (st_s == ST_DRAIN1) begin
                        state_d = ST_DELAY;
                        i_d     = {arg_width{1'b0}};
                    end else if (st_s == ST_DRAIN2) begin
                        state_d = ST_RANDOM;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (wait_q == TMO_LAST) begin
                    state_d = ST_DONE;
                    err_t_d = 1'b1;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            ST_DELAY: begin
                if (can_issue_s) begin
                    arg_vld_d = 1'b1;
                    a_d       = i_s;
                    b_d       = i_s + ONE;
                    c_d       = i_s << 1;
                    gap_d     = i_s >> 3;
                    i_d       = i_next_s;
                    if ((i_s >> 3) != {arg_width{1'b0}}) begin
                        state_d = ST_GAP;
                    end else if (i_next_s >= DELAY_LIMIT) begin
                        state_d = ST_DRAIN2;
                    end else begin
                        state_d = ST_DELAY;
                    end
                end else begin
                    state_d = ST_DELAY;
                end
            end
            ST_GAP: begin
                if (gap_q > ONE) begin
                    gap_d = gap_q - ONE;
                end else if (i_q >= DELAY_LIMIT) begin
                    state_d = ST_DRAIN2;
                end else begin
                    state_d = ST_DELAY;
                end
            end
            ST_RANDOM: begin
                if (can_issue_s) begin
                    arg_vld_d = 1'b1;
                    a_d       = arg_width'(lfsr_s);
                    b_d       = arg_width'(rotl32(lfsr_s, 11));
                    c_d       = arg_width'(rotl32(lfsr_s, 22));
                    lfsr_d    = lfsr_step(lfsr_s);
                    gap_d     = arg_width'(lfsr_s[3:0]);
                    rnd_d     = rnd_next_s;
                    if (rnd_next_s >= N_RND) begin
                        state_d = ST_DRAIN3;
                    end else if (lfsr_s[3:0] != 4'd0) begin
                        state_d = ST_RGAP;
                    end else begin
                        state_d = ST_RANDOM;
                    end
                end else begin
                    state_d = ST_RANDOM;
                end
            end
            ST_RGAP: begin
                if (gap_q > ONE) begin
                    gap_d = gap_q - ONE;
                end else begin
                    state_d = ST_RANDOM;
                end
            end
            ST_IDLE, ST_DONE: begin
                state_d = st_s;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        arg_cnt_d = arg_vld_d ? sat_inc16(arg_base_s) : arg_base_s;
        busy_d    = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d    = (state_d == ST_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            i_q       <= {arg_width{1'b0}};
            gap_q     <= {arg_width{1'b0}};
            a_q       <= {arg_width{1'b0}};
            b_q       <= {arg_width{1'b0}};
            c_q       <= {arg_width{1'b0}};
            lfsr_q    <= SEED;
            wait_q    <= 32'd0;
            out_q     <= 16'd0;
            rnd_q     <= 16'd0;
            arg_cnt_q <= 16'd0;
            res_cnt_q <= 16'd0;
            arg_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_u_q   <= 1'b0;
            err_t_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            gap_q     <= gap_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            lfsr_q    <= lfsr_d;
            wait_q    <= wait_d;
            out_q     <= out_d;
            rnd_q     <= rnd_d;
            arg_cnt_q <= arg_cnt_d;
            res_cnt_q <= res_cnt_d;
            arg_vld_q <= arg_vld_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_u_q   <= err_u_d;
            err_t_q   <= err_t_d;
        end
    end

    assign arg_vld       = arg_vld_q;
    assign a             = a_q;
    assign b             = b_q;
    assign c             = c_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_underflow = err_u_q;
    assign err_timeout   = err_t_q;
    assign arg_cnt       = arg_cnt_q;
    assign res_cnt       = res_cnt_q;

endmodule

// File: tb/tb_formula_arg_gen.sv
// Directed bench for formula_arg_gen: echo-pipe sinks with 3- and 10-cycle latency,
// a silent sink for the drain timeout, and hand-computed argument sequences.
module tb_formula_arg_gen;

    logic        clk = 1'b0;
    logic        rst, start, start2, echo_en, res_man;
    logic        res_vld, res_vld2;
    logic        arg_vld, busy, done, err_u, err_t;
    logic        arg_vld2, busy2, done2, err_u2, err_t2;
    logic [31:0] a, b, c, a2, b2, c2;
    logic [15:0] arg_cnt, res_cnt, arg_cnt2, res_cnt2;
    logic [2:0]  sh;
    logic [9:0]  sh2;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    formula_arg_gen dut (
        .clk(clk), .rst(rst), .start(start), .res_vld(res_vld),
        .arg_vld(arg_vld), .a(a), .b(b), .c(c), .busy(busy), .done(done),
        .err_underflow(err_u), .err_timeout(err_t), .arg_cnt(arg_cnt), .res_cnt(res_cnt)
    );

    formula_arg_gen #(.max_outstanding(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .res_vld(res_vld2),
        .arg_vld(arg_vld2), .a(a2), .b(b2), .c(c2), .busy(busy2), .done(done2),
        .err_underflow(err_u2), .err_timeout(err_t2), .arg_cnt(arg_cnt2), .res_cnt(res_cnt2)
    );

    // Echo sinks: results return 3 (dut) and 10 (dut2) cycles after each argument.
    always @(posedge clk) begin
        if (rst) begin
            sh  <= 3'b0;
            sh2 <= 10'b0;
        end else begin
            sh  <= {sh[1:0], arg_vld};
            sh2 <= {sh2[8:0], arg_vld2};
        end
    end
    assign res_vld  = echo_en ? sh[2] : res_man;
    assign res_vld2 = sh2[9];

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        lfsr_next = v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
    endfunction

    task automatic pulse_start;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; start2 = 1'b0; echo_en = 1'b1; res_man = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({arg_vld, busy, done, err_u, err_t} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got vld/busy/done/eu/et=%b want 00000", {arg_vld, busy, done, err_u, err_t});
        end
        n_checks++;
        if ({a, b, c} !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_args: got a=%0h b=%0h c=%0h want 0", a, b, c);
        end
        n_checks++;
        if ({arg_cnt, res_cnt} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_cnt: got arg_cnt=%0d res_cnt=%0d want 0", arg_cnt, res_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_burst;
        int bv[5] = '{0, 1, 4, 13, 40};
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (arg_vld !== 1'b1 || a !== 32'(bv[k]) || b !== 32'(bv[k]) || c !== 32'(bv[k])) begin
                n_fail++;
                $display("FAIL burst[%0d]: got vld=%b a=%0d b=%0d c=%0d want vld=1 a=b=c=%0d", k, arg_vld, a, b, c, bv[k]);
            end
            @(negedge clk);
        end
        n_checks++;
        if (arg_vld !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL burst_end: got vld=%b busy=%b want vld=0 busy=1", arg_vld, busy);
        end
    endtask

    task automatic test_delay;
        int dv[7] = '{0, 1, 4, 13, 40, 121, 364};
        int gv[6] = '{0, 0, 0, 1, 5, 15};
        int n;
        for (int k = 0; k < 7; k++) begin
            n = 0;
            while (arg_vld !== 1'b1 && n < 300) begin
                @(negedge clk);
                n++;
            end
            n_checks++;
            if (arg_vld !== 1'b1) begin
                n_fail++;
                $display("FAIL delay_wait[%0d]: got no arg_vld within %0d cycles, want one", k, n);
            end
            if (k > 0) begin
                n_checks++;
                if (n !== gv[k-1]) begin
                    n_fail++;
                    $display("FAIL delay_gap[%0d]: got %0d idle cycles want %0d", k, n, gv[k-1]);
                end
            end
            n_checks++;
            if (a !== 32'(dv[k]) || b !== 32'(dv[k] + 1) || c !== 32'(dv[k] * 2)) begin
                n_fail++;
                $display("FAIL delay_arg[%0d]: got a=%0d b=%0d c=%0d want %0d %0d %0d", k, a, b, c, dv[k], dv[k] + 1, dv[k] * 2);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random;
        logic [31:0] l;
        int n;
        l = 32'h1;
        for (int k = 0; k < 10; k++) begin
            n = 0;
            while (arg_vld !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            n_checks++;
            if (arg_vld !== 1'b1 || a !== l || b !== {l[20:0], l[31:21]} || c !== {l[9:0], l[31:10]}) begin
                n_fail++;
                $display("FAIL random[%0d]: got vld=%b a=%h b=%h c=%h want a=%h b=%h c=%h", k, arg_vld, a, b, c, l, {l[20:0], l[31:21]}, {l[9:0], l[31:10]});
            end
            l = lfsr_next(l);
            @(negedge clk);
        end
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || arg_cnt !== 16'd22 || res_cnt !== 16'd22 || err_u !== 1'b0 || err_t !== 1'b0) begin
            n_fail++;
            $display("FAIL run_end: got done=%b busy=%b arg=%0d res=%0d eu=%b et=%b want 1 0 22 22 0 0", done, busy, arg_cnt, res_cnt, err_u, err_t);
        end
    endtask

    task automatic test_underflow;
        echo_en = 1'b0;
        res_man = 1'b1;
        @(negedge clk) res_man = 1'b0;
        n_checks++;
        if (err_u !== 1'b1 || res_cnt !== 16'd23) begin
            n_fail++;
            $display("FAIL underflow: got eu=%b res_cnt=%0d want 1 23", err_u, res_cnt);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (err_u !== 1'b1) begin
            n_fail++;
            $display("FAIL underflow_sticky: got eu=%b want 1", err_u);
        end
    endtask

    task automatic test_timeout;
        int n;
        pulse_start();
        n_checks++;
        if (err_u !== 1'b0 || res_cnt !== 16'd0 || arg_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL start_clear: got eu=%b res_cnt=%0d vld=%b want 0 0 1", err_u, res_cnt, arg_vld);
        end
        n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (done !== 1'b1 || n !== 1004) begin
            n_fail++;
            $display("FAIL timeout_time: got done=%b after %0d cycles want done=1 after 1004", done, n);
        end
        n_checks++;
        if (err_t !== 1'b1 || arg_cnt !== 16'd5 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_state: got et=%b arg_cnt=%0d busy=%b want 1 5 0", err_t, arg_cnt, busy);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        echo_en = 1'b1;
        pulse_start();
        n = 0;
        while (!(arg_vld === 1'b1 && a === 32'd13 && b === 32'd14) && n < 300) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (b !== 32'd14) begin
            n_fail++;
            $display("FAIL mid_reach_delay: got b=%0d want 14", b);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (arg_vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || arg_cnt !== 16'd0 || res_cnt !== 16'd0 || a !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got vld=%b busy=%b done=%b arg=%0d res=%0d a=%0d want all 0", arg_vld, busy, done, arg_cnt, res_cnt, a);
        end
        rst = 1'b0;
        test_burst();
        test_delay();
        test_random();
    endtask

    task automatic test_credit;
        int cyc, sent, ret, infl, maxinf, third;
        sent = 0; ret = 0; maxinf = 0; third = -1; cyc = 0;
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        while (done2 !== 1'b1 && cyc < 4000) begin
            if (arg_vld2 === 1'b1) begin
                sent++;
                if (sent == 3) third = cyc;
            end
            infl = sent - ret;
            if (infl > maxinf) maxinf = infl;
            if (res_vld2 === 1'b1) ret++;
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (maxinf !== 2) begin
            n_fail++;
            $display("FAIL credit_max: got %0d in flight want 2", maxinf);
        end
        n_checks++;
        if (third !== 11) begin
            n_fail++;
            $display("FAIL credit_stall: got third arg at cycle %0d want 11", third);
        end
        n_checks++;
        if (done2 !== 1'b1 || arg_cnt2 !== 16'd22 || res_cnt2 !== 16'd22 || err_u2 !== 1'b0 || err_t2 !== 1'b0) begin
            n_fail++;
            $display("FAIL credit_end: got done=%b arg=%0d res=%0d eu=%b et=%b want 1 22 22 0 0", done2, arg_cnt2, res_cnt2, err_u2, err_t2);
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_delay();
        test_random();
        test_underflow();
        test_timeout();
        test_reset_mid();
        test_credit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
